// File: rtl/alu_mdu_seq_pkg.sv
// Shared opcode encoding for the RV32IM execute-stage ALU/MDU.
// Base ALU, branch-compare and M-extension operations share one 5-bit space.
package alu_mdu_seq_pkg;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_SLL  = 5'd2,
        ALU_SLT  = 5'd3,
        ALU_SLTU = 5'd4,
        ALU_XOR  = 5'd5,
        ALU_SRL  = 5'd6,
        ALU_SRA  = 5'd7,
        ALU_OR   = 5'd8,
        ALU_AND  = 5'd9,
        ALU_LUI  = 5'd10,
        B_BEQ    = 5'd11,
        B_BNE    = 5'd12,
        B_BLT    = 5'd13,
        B_BGE    = 5'd14,
        B_LTU    = 5'd15,
        B_GEU    = 5'd16,
        MUL      = 5'd17,
        MULH     = 5'd18,
        MULHSU   = 5'd19,
        MULHU    = 5'd20,
        DIV      = 5'd21,
        DIVU     = 5'd22,
        REM      = 5'd23,
        REMU     = 5'd24
    } alu_op_t;

    function automatic logic isDivOp(alu_op_t op);
        return op inside {DIV, DIVU, REM, REMU};
    endfunction

endpackage

// File: rtl/alu_mdu_seq_if.sv
// Operand/result handshake bundle between ID/EX and EX/MEM around alu_mdu_seq.
interface alu_mdu_seq_if import alu_mdu_seq_pkg::*; #(parameter int WIDTH = 32) ();

    logic             in_valid;
    logic             in_ready;
    alu_op_t          control;
    logic [WIDTH-1:0] left_operand;
    logic [WIDTH-1:0] right_operand;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero_flag;
    logic             branch_taken;

    modport master (
        output in_valid, control, left_operand, right_operand, out_ready,
        input  in_ready, out_valid, result, zero_flag, branch_taken
    );

    modport slave (
        input  in_valid, control, left_operand, right_operand, out_ready,
        output in_ready, out_valid, result, zero_flag, branch_taken
    );

endinterface

// File: rtl/alu_mdu_seq_div_iter.sv
// Radix-2 restoring divider on operand magnitudes, one quotient bit per cycle.
// The first bit is produced on the start edge so quo/rem are ready WIDTH cycles later.
module div_iter import alu_mdu_seq_pkg::*; #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             abort_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             is_signed_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quo_o,
    output logic [WIDTH-1:0] rem_o
);

    logic             busy_q, negQ_q, negR_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] rem_q, quo_q, dsr_q;

    logic             dvdNeg, dsrNeg;
    logic [WIDTH-1:0] remSrc, quoSrc, dsrSrc, remNext, quoNext;
    logic [WIDTH:0]   shifted, diff;

    always_comb begin
        dvdNeg  = is_signed_i && dividend_i[WIDTH-1];
        dsrNeg  = is_signed_i && divisor_i[WIDTH-1];
        remSrc  = start_i ? '0 : rem_q;
        quoSrc  = start_i ? (dvdNeg ? -dividend_i : dividend_i) : quo_q;
        dsrSrc  = start_i ? (dsrNeg ? -divisor_i : divisor_i) : dsr_q;
        shifted = {remSrc, quoSrc[WIDTH-1]};
        diff    = shifted - {1'b0, dsrSrc};
        remNext = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        quoNext = {quoSrc[WIDTH-2:0], ~diff[WIDTH]};
    end

    // A zero divisor never flips the quotient sign, so it stays all ones.
    always_ff @(posedge clk) begin
        if (!reset_n || abort_i) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dsr_q  <= '0;
            negQ_q <= 1'b0;
            negR_q <= 1'b0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            cnt_q  <= CNT_W'(WIDTH - 1);
            rem_q  <= remNext;
            quo_q  <= quoNext;
            dsr_q  <= dsrSrc;
            negQ_q <= (dvdNeg ^ dsrNeg) && (divisor_i != '0);
            negR_q <= dvdNeg;
        end else if (busy_q) begin
            if (cnt_q == '0) begin
                busy_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - CNT_W'(1);
                rem_q <= remNext;
                quo_q <= quoNext;
            end
        end
    end

    assign busy_o = busy_q;
    assign done_o = busy_q && (cnt_q == '0);
    assign quo_o  = negQ_q ? -quo_q : quo_q;
    assign rem_o  = negR_q ? -rem_q : rem_q;

endmodule

// File: rtl/alu_mdu_seq.sv
// Handshaked RV32IM execute unit: single-cycle ALU/branch/MUL ops and an iterative divider.
module alu_mdu_seq import alu_mdu_seq_pkg::*; #(
    parameter int WIDTH     = 32,
    parameter int SHAMT_W   = $clog2(WIDTH),
    parameter bit FAST_DIV0 = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic flush_i,
    alu_mdu_seq_if.slave bus
);

    typedef enum logic [1:0] {IDLE, DIV_BUSY, DONE} mdu_state_t;

    mdu_state_t       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d, br_q, br_d, isRem_q, isRem_d;

    logic             accept, divStart, divBusy, divDone;
    logic [WIDTH-1:0] divQuo, divRem, divRes;
    logic [WIDTH-1:0] opA, opB, aluRes;
    logic [SHAMT_W-1:0] shamt;
    logic [2*WIDTH-1:0] mulA, mulB, prod;
    logic             brTaken, fastDiv, divZero, divOvf;

    assign bus.in_ready  = (state_q == IDLE) || (state_q == DONE && bus.out_ready);
    assign bus.out_valid = (state_q == DONE);
    assign bus.result       = result_q;
    assign bus.zero_flag    = zero_q;
    assign bus.branch_taken = br_q;
    assign accept = bus.in_valid && bus.in_ready && !flush_i;
    assign divRes = isRem_q ? divRem : divQuo;

    // One shared 2*WIDTH multiplier; operand extension selects the signedness of MULH*.
    always_comb begin
        opA     = bus.left_operand;
        opB     = bus.right_operand;
        shamt   = opB[SHAMT_W-1:0];
        mulA    = {{WIDTH{(bus.control inside {MULH, MULHSU}) && opA[WIDTH-1]}}, opA};
        mulB    = {{WIDTH{(bus.control == MULH) && opB[WIDTH-1]}}, opB};
        prod    = mulA * mulB;
        divZero = (opB == '0);
        divOvf  = (bus.control inside {DIV, REM}) && (opA == {1'b1, {(WIDTH-1){1'b0}}}) && (opB == '1);
        fastDiv = FAST_DIV0 && (divZero || divOvf);
        brTaken = 1'b0;
        aluRes  = '0;
        unique case (bus.control)
            ALU_ADD:  aluRes = opA + opB;
            ALU_SUB:  aluRes = opA - opB;
            ALU_SLL:  aluRes = opA << shamt;
            ALU_SLT:  aluRes = WIDTH'($signed(opA) < $signed(opB));
            ALU_SLTU: aluRes = WIDTH'(opA < opB);
            ALU_XOR:  aluRes = opA ^ opB;
            ALU_SRL:  aluRes = opA >> shamt;
            ALU_SRA:  aluRes = WIDTH'($signed(opA) >>> shamt);
            ALU_OR:   aluRes = opA | opB;
            ALU_AND:  aluRes = opA & opB;
            ALU_LUI:  aluRes = opB;
            B_BEQ:    brTaken = (opA == opB);
            B_BNE:    brTaken = (opA != opB);
            B_BLT:    brTaken = ($signed(opA) < $signed(opB));
            B_BGE:    brTaken = ($signed(opA) >= $signed(opB));
            B_LTU:    brTaken = (opA < opB);
            B_GEU:    brTaken = (opA >= opB);
            MUL:      aluRes = prod[WIDTH-1:0];
            MULH, MULHSU, MULHU: aluRes = prod[2*WIDTH-1:WIDTH];
            DIV, DIVU, REM, REMU: begin
                if (divZero)
                    aluRes = (bus.control inside {REM, REMU}) ? opA : '1;
                else if (divOvf)
                    aluRes = (bus.control == REM) ? '0 : opA;
            end
            default:  aluRes = '0;
        endcase
        if (bus.control inside {B_BEQ, B_BNE, B_BLT, B_BGE, B_LTU, B_GEU})
            aluRes = WIDTH'(brTaken);
    end

    // Next-state: consume and accept may coincide in DONE, giving back-to-back issue.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        br_d     = br_q;
        isRem_d  = isRem_q;
        divStart = 1'b0;
        if (flush_i) begin
            state_d = IDLE;
        end else begin
            if (state_q == DONE && bus.out_ready)
                state_d = IDLE;
            if (state_q == DIV_BUSY) begin
                if (divDone) begin
                    state_d  = DONE;
                    result_d = divRes;
                    zero_d   = (divRes == '0);
                    br_d     = 1'b0;
                end else if (!divBusy) begin
                    state_d = IDLE;
                end
            end
            if (accept) begin
                if (isDivOp(bus.control) && !fastDiv) begin
                    state_d  = DIV_BUSY;
                    divStart = 1'b1;
                    isRem_d  = bus.control inside {REM, REMU};
                end else begin
                    state_d  = DONE;
                    result_d = aluRes;
                    zero_d   = (aluRes == '0);
                    br_d     = brTaken;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
            br_q     <= 1'b0;
            isRem_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            br_q     <= br_d;
            isRem_q  <= isRem_d;
        end
    end

    div_iter #(.WIDTH(WIDTH), .CNT_W(SHAMT_W + 1)) u_div (
        .clk        (clk),
        .reset_n    (reset_n),
        .abort_i    (flush_i),
        .start_i    (divStart),
        .dividend_i (opA),
        .divisor_i  (opB),
        .is_signed_i(bus.control inside {DIV, REM}),
        .busy_o     (divBusy),
        .done_o     (divDone),
        .quo_o      (divQuo),
        .rem_o      (divRem)
    );

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Directed bench for alu_mdu_seq: expectations queued at accept, checked as results are consumed.
module tb_alu_mdu_seq;
    import alu_mdu_seq_pkg::*;

    typedef struct {
        logic [31:0] res;
        logic        br;
        int          acceptCycle;
        int          lat;
        string       tag;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    logic flush;
    int   errors = 0;
    int   checks = 0;
    int   cycle  = 0;
    exp_t sb[$];
    exp_t monE;

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    alu_mdu_seq_if #(.WIDTH(32)) bus ();

    alu_mdu_seq #(.WIDTH(32), .SHAMT_W(5), .FAST_DIV0(1'b1)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .flush_i(flush),
        .bus    (bus)
    );

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Consumer side: every consumed result must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reset_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("[TB] FAIL unexpected_output: observed %h expected none", bus.result);
            end else begin
                monE = sb.pop_front();
                checkEq({monE.tag, ".result"}, bus.result, monE.res);
                checkEq({monE.tag, ".zero"}, 32'(bus.zero_flag), 32'(monE.res == 32'd0));
                checkEq({monE.tag, ".branch"}, 32'(bus.branch_taken), 32'(monE.br));
                if (monE.lat != 0)
                    checkEq({monE.tag, ".latency"}, 32'(cycle - monE.acceptCycle), 32'(monE.lat));
            end
        end
    end

    task automatic applyStimulus(input alu_op_t op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] expRes, input logic expBr, input int expLat,
                                 input bit expectOut, input string tag);
        exp_t e;
        int guard = 0;
        bus.control       = op;
        bus.left_operand  = a;
        bus.right_operand = b;
        bus.in_valid      = 1'b1;
        while (!bus.in_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        checkEq({tag, ".accept"}, 32'(bus.in_ready), 32'd1);
        if (expectOut) begin
            e.res = expRes; e.br = expBr; e.acceptCycle = cycle; e.lat = expLat; e.tag = tag;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic waitDrain(input string tag);
        int guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        checkEq({tag, ".drain"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic checkOutput(input string tag, input int nCycles);
        logic sawValid = 1'b0;
        for (int i = 0; i < nCycles; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) sawValid = 1'b1;
        end
        checkEq({tag, ".no_output"}, 32'(sawValid), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        flush   = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.control = ALU_ADD;
        bus.left_operand = '0;
        bus.right_operand = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
        checkEq("reset.out_valid", 32'(bus.out_valid), 32'd0);
        checkEq("reset.result", bus.result, 32'd0);
        checkEq("reset.zero", 32'(bus.zero_flag), 32'd0);
        checkEq("reset.branch", 32'(bus.branch_taken), 32'd0);
        checkEq("reset.in_ready", 32'(bus.in_ready), 32'd1);

        // Back-to-back single-cycle ops with no bubble.
        applyStimulus(ALU_ADD, 32'd5, 32'd7, 32'd12, 1'b0, 1, 1'b1, "add");
        checkEq("b2b.in_ready", 32'(bus.in_ready), 32'd1);
        applyStimulus(ALU_SUB, 32'd3, 32'd3, 32'd0, 1'b0, 1, 1'b1, "sub");
        applyStimulus(ALU_SRA, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b0, 1, 1'b1, "sra");
        applyStimulus(ALU_SLL, 32'd1, 32'h0000_00FF, 32'h8000_0000, 1'b0, 1, 1'b1, "sll");
        applyStimulus(ALU_LUI, 32'h1234_5678, 32'hABCD_E000, 32'hABCD_E000, 1'b0, 1, 1'b1, "lui");
        waitDrain("alu");

        applyStimulus(MUL, 32'd6, 32'd7, 32'd42, 1'b0, 1, 1'b1, "mul");
        applyStimulus(MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 1, 1'b1, "mulh");
        applyStimulus(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1, 1'b1, "mulhu");
        applyStimulus(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1, 1'b1, "mulhsu");
        waitDrain("mul");

        applyStimulus(B_BLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b1, 1, 1'b1, "blt");
        applyStimulus(B_LTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1, 1'b1, "bltu");
        applyStimulus(B_BEQ, 32'd9, 32'd9, 32'd1, 1'b1, 1, 1'b1, "beq");
        applyStimulus(alu_op_t'(5'd31), 32'd9, 32'd9, 32'd0, 1'b0, 1, 1'b1, "unknown");
        waitDrain("branch");

        // Iterative divides take WIDTH+1 cycles; special cases complete in one.
        applyStimulus(DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 33, 1'b1, "div_neg");
        applyStimulus(REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 33, 1'b1, "rem_neg");
        applyStimulus(DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 33, 1'b1, "divu");
        applyStimulus(REMU, 32'd100, 32'd7, 32'd2, 1'b0, 33, 1'b1, "remu");
        applyStimulus(DIVU, 32'd7, 32'd0, 32'hFFFF_FFFF, 1'b0, 1, 1'b1, "divu_zero");
        applyStimulus(REMU, 32'd7, 32'd0, 32'd7, 1'b0, 1, 1'b1, "remu_zero");
        applyStimulus(REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 1, 1'b1, "rem_ovf");
        applyStimulus(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1, 1'b1, "div_ovf");
        waitDrain("div");

        // Backpressure holds the result and blocks new work.
        bus.out_ready = 1'b0;
        applyStimulus(ALU_ADD, 32'd10, 32'd20, 32'd30, 1'b0, 0, 1'b1, "hold");
        for (int i = 0; i < 5; i++) begin
            checkEq("hold.out_valid", 32'(bus.out_valid), 32'd1);
            checkEq("hold.result", bus.result, 32'd30);
            checkEq("hold.in_ready", 32'(bus.in_ready), 32'd0);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        waitDrain("hold");

        // Flush on the tenth cycle of a divide drops it entirely.
        applyStimulus(DIVU, 32'd100, 32'd7, 32'd0, 1'b0, 0, 1'b0, "flush_div");
        repeat (8) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checkEq("flush.in_ready", 32'(bus.in_ready), 32'd1);
        checkEq("flush.out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("flush", 40);

        // Reset mid-divide also produces no output.
        applyStimulus(DIV, 32'd1000, 32'd3, 32'd0, 1'b0, 0, 1'b0, "rst_div");
        repeat (5) @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        checkOutput("rst_div", 40);

        applyStimulus(ALU_ADD, 32'd1, 32'd1, 32'd2, 1'b0, 1, 1'b1, "post_flush");
        waitDrain("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
